// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first: one WIDTH-bit word out and one in per frame, all registered in clk.
// Frame = CLKDIV setup + 2*WIDTH half-periods + CLKDIV hold, then SEL_GAP cycles of deselect.
module spi_master #(
    parameter int WIDTH   = 8,
    parameter int CLKDIV  = 8,
    parameter int SEL_GAP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             ucSCLK,
    output logic             ucMOSI,
    input  logic             ucMISO,
    output logic             ucSEL_
);
    localparam int DW = $clog2(CLKDIV);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(SEL_GAP + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(SEL_GAP);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_sh;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             accept;

    // The final GAP cycle may accept directly so a held start sees ucSEL_ high for exactly SEL_GAP cycles.
    assign accept = start && ((state == IDLE) || (state == GAP && gap_cnt == GAP_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ucSEL_   <= 1'b1;
            ucSCLK   <= 1'b0;
            ucMOSI   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                tx_sh   <= data_in;
                rx_sh   <= '0;
                ucMOSI  <= data_in[WIDTH-1];
                ucSEL_  <= 1'b0;
                ucSCLK  <= 1'b0;
                busy    <= 1'b1;
                div_cnt <= '0;
                bit_cnt <= '0;
                state   <= SETUP;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    SETUP: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            state   <= XFER;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    XFER: begin
                        if (div_cnt != DIV_LAST) begin
                            div_cnt <= div_cnt + 1'b1;
                        end else begin
                            div_cnt <= '0;
                            ucSCLK  <= ~ucSCLK;
                            // End of a high half: sample MISO late, then present the next MOSI bit.
                            if (ucSCLK) begin
                                rx_sh   <= {rx_sh[WIDTH-2:0], ucMISO};
                                tx_sh   <= {tx_sh[WIDTH-2:0], 1'b0};
                                ucMOSI  <= tx_sh[WIDTH-2];
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt == BIT_LAST) begin
                                    state <= HOLD;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt  <= '0;
                            ucSEL_   <= 1'b1;
                            data_out <= rx_sh;
                            done     <= 1'b1;
                            gap_cnt  <= GW'(1);
                            state    <= GAP;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: begin
                        busy   <= 1'b0;
                        ucSEL_ <= 1'b1;
                        ucSCLK <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: behavioural mode-0 slave or loopback on MISO, table + random frames, corner sequences.
module tb_spi_master;
    localparam int W   = 8;
    localparam int DIV = 4;
    localparam int GAP = 4;
    localparam int LAT = (2 * W + 2) * DIV;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         busy, done, ucSCLK, ucMOSI, ucMISO, ucSEL_;
    logic [W-1:0] data_out;

    spi_master #(.WIDTH(W), .CLKDIV(DIV), .SEL_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy), .done(done), .data_out(data_out),
        .ucSCLK(ucSCLK), .ucMOSI(ucMOSI), .ucMISO(ucMISO), .ucSEL_(ucSEL_)
    );

    always #5 clk = ~clk;

    // Slave side: either echo MOSI or shift out slave_word MSB first.
    bit           loopback = 1'b0;
    logic [W-1:0] slave_word = '0;
    logic [W-1:0] slv_sh = '0;
    logic [W-1:0] slv_rx = '0;
    logic         slv_miso = 1'b0;
    assign ucMISO = loopback ? ucMOSI : slv_miso;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rises, unstable, done_cnt, latency, fall_cyc, sel_run;
    logic [W-1:0] mosi_rise;
    int gaps[$];
    logic prev_sel = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] sw;
        bit           lb;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_slv;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_rx(input logic [W-1:0] din, input logic [W-1:0] sw, input bit lb);
        return lb ? din : sw;
    endfunction

    task automatic clear_mon();
        rises = 0; unstable = 0; done_cnt = 0; latency = -1; mosi_rise = '0;
    endtask

    // One clock: sample just after the edge and advance the bus observers and slave model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_sel && !ucSEL_) begin
            gaps.push_back(sel_run);
            sel_run = 0;
            fall_cyc = cyc;
            slv_sh = slave_word;
            slv_rx = '0;
        end
        if (ucSEL_) sel_run++;
        if (!prev_sclk && ucSCLK) begin
            rises++;
            mosi_rise = {mosi_rise[W-2:0], ucMOSI};
            slv_rx = {slv_rx[W-2:0], ucMOSI};
        end
        if (prev_sclk && !ucSCLK && !ucSEL_) slv_sh = {slv_sh[W-2:0], 1'b0};
        if (prev_sclk && ucSCLK && ucMOSI != prev_mosi) unstable++;
        if (done) begin
            done_cnt++;
            latency = cyc - fall_cyc;
        end
        slv_miso = slv_sh[W-1];
        prev_sel = ucSEL_; prev_sclk = ucSCLK; prev_mosi = ucMOSI;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin tick(); n++; end
        if (busy) check("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic wait_done(input string name, input int target);
        int n = 0;
        while (done_cnt < target && n < 2000) begin tick(); n++; end
        check({name, "_done_seen"}, 32'(done_cnt >= target), 32'(1));
    endtask

    task automatic run_frame(input string name, input logic [W-1:0] din, input logic [W-1:0] sw,
                             input bit lb, input logic [W-1:0] exp_out, input logic [W-1:0] exp_slv);
        wait_idle();
        clear_mon();
        slave_word = sw; loopback = lb; data_in = din; start = 1'b1;
        tick();
        start = 1'b0;
        data_in = W'($urandom);
        wait_done(name, 1);
        check({name, "_data_out"}, 32'(data_out), 32'(exp_out));
        check({name, "_latency"}, 32'(latency), 32'(LAT));
        check({name, "_rises"}, 32'(rises), 32'(W));
        check({name, "_mosi_bits"}, 32'(mosi_rise), 32'(din));
        check({name, "_slave_rx"}, 32'(slv_rx), 32'(exp_slv));
        check({name, "_mosi_stable"}, 32'(unstable), 32'(0));
        repeat (GAP + 10) tick();
        check({name, "_one_done"}, 32'(done_cnt), 32'(1));
        check({name, "_idle"}, 32'({busy, ucSEL_, ucSCLK}), 32'(3'b010));
    endtask

    initial begin
        logic [W-1:0] d, s;
        bit l;
        sel_run = 0; fall_cyc = 0;
        clear_mon();
        vecs[0] = '{din: 8'hA5, sw: 8'h00, lb: 1'b1, exp_out: 8'hA5, exp_slv: 8'hA5};
        vecs[1] = '{din: 8'h0F, sw: 8'h3C, lb: 1'b0, exp_out: 8'h3C, exp_slv: 8'h0F};
        vecs[2] = '{din: 8'h0A, sw: 8'h05, lb: 1'b0, exp_out: 8'h05, exp_slv: 8'h0A};
        vecs[3] = '{din: 8'h81, sw: 8'h7E, lb: 1'b0, exp_out: 8'h7E, exp_slv: 8'h81};

        repeat (3) tick();
        check("rst_sel", 32'(ucSEL_), 32'(1));
        check("rst_sclk", 32'(ucSCLK), 32'(0));
        check("rst_mosi", 32'(ucMOSI), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_data_out", 32'(data_out), 32'(0));
        rst = 1'b0;
        tick();

        foreach (vecs[i])
            run_frame($sformatf("vec%0d", i), vecs[i].din, vecs[i].sw, vecs[i].lb,
                      vecs[i].exp_out, vecs[i].exp_slv);

        for (int i = 0; i < 8; i++) begin
            d = W'($urandom); s = W'($urandom); l = 1'($urandom_range(0, 1));
            run_frame($sformatf("rnd%0d", i), d, s, l, model_rx(d, s, l), d);
        end

        // Second start mid-frame must be ignored.
        wait_idle(); clear_mon();
        loopback = 1'b0; slave_word = 8'h6B; data_in = 8'h12; start = 1'b1;
        tick(); start = 1'b0;
        repeat (20) tick();
        data_in = 8'hFF; start = 1'b1;
        tick(); start = 1'b0;
        wait_done("mid", 1);
        check("mid_data_out", 32'(data_out), 32'(8'h6B));
        check("mid_mosi_bits", 32'(mosi_rise), 32'(8'h12));
        repeat (100) tick();
        check("mid_one_done", 32'(done_cnt), 32'(1));
        check("mid_rises", 32'(rises), 32'(W));
        check("mid_idle", 32'(busy), 32'(0));

        // Start held: three back-to-back frames, deselect exactly GAP cycles between them.
        wait_idle(); clear_mon(); gaps.delete();
        loopback = 1'b1; data_in = 8'hC3; start = 1'b1;
        wait_done("held", 3);
        start = 1'b0;
        check("held_data_out", 32'(data_out), 32'(8'hC3));
        check("held_latency", 32'(latency), 32'(LAT));
        repeat (30) tick();
        check("held_done_total", 32'(done_cnt), 32'(3));
        check("held_frames", 32'(gaps.size()), 32'(3));
        check("held_gap1", 32'(gaps.size() > 1 ? gaps[1] : -1), 32'(GAP));
        check("held_gap2", 32'(gaps.size() > 2 ? gaps[2] : -1), 32'(GAP));
        check("held_rises", 32'(rises), 32'(3 * W));

        // Reset after the third rising edge aborts the frame with no done.
        wait_idle(); clear_mon();
        loopback = 1'b0; slave_word = 8'h5A; data_in = 8'h99; start = 1'b1;
        tick(); start = 1'b0;
        begin
            int n = 0;
            while (rises < 3 && n < 500) begin tick(); n++; end
        end
        check("abort_reached_edge3", 32'(rises), 32'(3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sel", 32'(ucSEL_), 32'(1));
        check("abort_sclk", 32'(ucSCLK), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        repeat (100) tick();
        check("abort_no_done", 32'(done_cnt), 32'(0));
        run_frame("after_abort", 8'h81, 8'h3E, 1'b0, 8'h3E, 8'h81);

        // rst and start together: rst wins.
        rst = 1'b1; start = 1'b1; data_in = 8'hAA;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start_sel", 32'(ucSEL_), 32'(1));
        check("rst_start_busy", 32'(busy), 32'(0));
        tick();
        check("rst_start_no_frame", 32'({busy, ucSEL_}), 32'(2'b01));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
